// File: rtl/stm32_bus_master.sv
// Parallel bus master. Payload bytes are queued in a circular buffer,
// then a command byte goes out with a strobe. Depending on the command,
// the master next writes queued bytes, reads bytes back from a responder
// after a turnaround cycle, or does neither. Each transfer ends with one
// gap cycle that pulses done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_SYNC  | DATA_SYNC high, command byte driven on DATA_BUS
// S_WRITE | one buffered payload byte driven per cycle
// S_TURN  | bus released for the responder's registered turnaround
// S_READ  | responder byte sampled at the end of every cycle
// S_GAP   | bus released, done pulses, back to idle
module stm32_bus_master #(
    parameter int BUF_DEPTH = 32
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_code,
    input  logic [7:0] cmd_len,
    output logic       DATA_SYNC,
    inout  wire  [7:0] DATA_BUS,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_WRITE,
        S_TURN,
        S_READ,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [7:0]    r_mem [BUF_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [7:0]    r_code;
    logic [7:0]    r_len_rem;
    logic          r_is_write;
    logic          r_is_read;
    logic          r_ready_en;
    logic          r_err;
    logic          r_rd_valid;
    logic [7:0]    r_rd_data;

    logic          w_cls_write;
    logic          w_cls_read;
    logic          w_cls_strobe;
    logic          w_len_ok;
    logic          w_accept;
    logic          w_start;
    logic          w_reject;
    logic          w_push;
    logic          w_pop;
    logic          w_last;
    logic          w_drive;
    logic [7:0]    w_bus_out;

    // Command decode. A write asking for more bytes than are queued is
    // refused up front, so WRITE can never run the buffer dry.
    always_comb begin
        w_cls_write  = (cmd_code == 8'd1) || (cmd_code == 8'd3);
        w_cls_read   = (cmd_code == 8'd2) || (cmd_code == 8'd4) || (cmd_code == 8'd8);
        w_cls_strobe = (cmd_code == 8'd5) || (cmd_code == 8'd6) ||
                       (cmd_code == 8'd9) || (cmd_code == 8'd10);
        w_len_ok     = !w_cls_write || (16'(cmd_len) <= 16'(r_count));
        w_accept     = cmd_valid && cmd_ready;
        w_start      = w_accept && (w_cls_write || w_cls_read || w_cls_strobe) && w_len_ok;
        w_reject     = w_accept && !w_start;
    end

    // Loads are blocked only while WRITE pops, so push and pop never coincide.
    always_comb begin
        w_pop     = (r_state == S_WRITE);
        w_push    = ld_valid && (r_state != S_WRITE) && (r_count != CW'(BUF_DEPTH));
        w_last    = (r_len_rem == 8'd1);
        w_drive   = (r_state == S_SYNC) || (r_state == S_WRITE);
        w_bus_out = (r_state == S_SYNC) ? r_code : r_mem[r_rd_ptr];
    end

    assign DATA_BUS  = w_drive ? w_bus_out : 8'bzzzz_zzzz;
    assign DATA_SYNC = (r_state == S_SYNC);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_GAP);
    assign cmd_ready = r_ready_en && (r_state == S_IDLE);
    assign err       = r_err;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

    // State register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (r_is_write && (r_len_rem != 8'd0)) begin
                    w_next = S_WRITE;
                end else if (r_is_read && (r_len_rem != 8'd0)) begin
                    w_next = S_TURN;
                end else begin
                    w_next = S_GAP;
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_next = S_GAP;
                end
            end
            S_TURN: begin
                w_next = S_READ;
            end
            S_READ: begin
                if (w_last) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the command at acceptance and count down the remaining bytes.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_code     <= 8'd0;
            r_len_rem  <= 8'd0;
            r_is_write <= 1'b0;
            r_is_read  <= 1'b0;
        end else if (w_start) begin
            r_code     <= cmd_code;
            r_len_rem  <= w_cls_strobe ? 8'd0 : cmd_len;
            r_is_write <= w_cls_write;
            r_is_read  <= w_cls_read;
        end else if ((r_state == S_WRITE) || (r_state == S_READ)) begin
            r_len_rem  <= r_len_rem - 8'd1;
        end
    end

    // Buffer pointers and fill count; pointers wrap naturally at BUF_DEPTH.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Buffer storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ld_data;
        end
    end

    // Status pulses, read sampling and the post-reset ready enable.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_en <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'd0;
        end else begin
            r_ready_en <= 1'b1;
            r_err      <= w_reject;
            r_rd_valid <= (r_state == S_READ);
            if (r_state == S_READ) begin
                r_rd_data <= DATA_BUS;
            end
        end
    end

endmodule

// File: tb/tb_stm32_bus_master.sv
// Bench for stm32_bus_master: directed scenarios plus randomized commands,
// checked cycle by cycle against a queue-based model of the payload buffer.
// Whenever the master must be off the bus, the responder parks it at 0x00.
// Any master drive then shows up as a non-zero or conflicting value.
module tb_stm32_bus_master;
    localparam int DEPTH = 32;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_len;
    logic       cmd_ready;
    logic       data_sync;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       err;
    wire  [7:0] data_bus;
    logic       resp_en;
    logic [7:0] resp_val;

    int total = 0;
    int bad   = 0;
    byte unsigned model_q[$];

    assign data_bus = resp_en ? resp_val : 8'hzz;

    stm32_bus_master #(.BUF_DEPTH(DEPTH)) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_len   (cmd_len),
        .DATA_SYNC (data_sync),
        .DATA_BUS  (data_bus),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // 0 = rejected, 1 = write, 2 = read, 3 = strobe only
    function automatic int cmd_class(input logic [7:0] code);
        case (code)
            8'd1, 8'd3:                return 1;
            8'd2, 8'd4, 8'd8:          return 2;
            8'd5, 8'd6, 8'd9, 8'd10:   return 3;
            default:                   return 0;
        endcase
    endfunction

    task automatic park();
        resp_en  = 1'b1;
        resp_val = 8'h00;
    endtask

    // Called and returns 1ns after a rising edge with the master idle.
    task automatic load_byte(input logic [7:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        @(posedge clk_in);
        #1;
        ld_valid = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(d);
    endtask

    task automatic check_reset_outputs(input string ctx);
        check_val({ctx, " sync"},   32'(data_sync), 32'd0);
        check_val({ctx, " bus"},    32'(data_bus),  32'h00);
        check_val({ctx, " ready"},  32'(cmd_ready), 32'd0);
        check_val({ctx, " busy"},   32'(busy),      32'd0);
        check_val({ctx, " done"},   32'(done),      32'd0);
        check_val({ctx, " err"},    32'(err),       32'd0);
        check_val({ctx, " rdv"},    32'(rd_valid),  32'd0);
        check_val({ctx, " rddata"}, 32'(rd_data),   32'h00);
    endtask

    // Issue one command and check every cycle until the master is idle again.
    // rd_base >= 0 makes the responder return rd_base, rd_base+1, ...
    // rst_at >= 0 pulls reset in that cycle and abandons the transfer.
    task automatic run_cmd(input logic [7:0] code, input logic [7:0] len,
                           input bit ld_rand, input int rd_base, input int rst_at);
        int         cls;
        int         n;
        int         gap;
        int         last_c;
        bit         rej;
        bit         in_write;
        bit         in_read;
        bit         ld_now;
        bit         exp_rdv;
        logic [7:0] exp_bus;
        logic [7:0] ld_byte;
        byte unsigned rd_q[$];
        string      ctx;
        string      tc;

        cls    = cmd_class(code);
        n      = (cls == 3) ? 0 : int'(len);
        rej    = (cls == 0) || ((cls == 1) && (n > model_q.size()));
        gap    = rej ? 0 : (((cls == 2) && (n > 0)) ? n + 2 : n + 1);
        last_c = rej ? 1 : gap + 1;
        ctx    = $sformatf("cmd%0h/len%0d", code, len);

        park();
        ld_valid  = 1'b0;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_len   = len;
        #1;
        check_val({ctx, " ready_at_issue"}, 32'(cmd_ready), 32'd1);
        @(posedge clk_in);
        #1;
        cmd_valid = 1'b0;
        cmd_code  = 8'($urandom);
        cmd_len   = 8'($urandom);

        for (int c = 0; c <= last_c; c++) begin
            tc       = $sformatf("%s c%0d", ctx, c);
            in_write = !rej && (cls == 1) && (c >= 1) && (c <= n);
            in_read  = !rej && (cls == 2) && (c >= 2) && (c <= n + 1);
            if (in_read) begin
                resp_en  = 1'b1;
                resp_val = (rd_base >= 0) ? 8'(rd_base + c - 2) : 8'($urandom);
                rd_q.push_back(resp_val);
            end else if ((!rej && (c == 0)) || in_write) begin
                resp_en = 1'b0;
            end else begin
                park();
            end
            ld_now   = ld_rand && ($urandom_range(0, 2) == 0);
            ld_byte  = 8'($urandom);
            ld_valid = ld_now;
            ld_data  = ld_byte;
            #1;

            if (!rej && (c == 0))  exp_bus = code;
            else if (in_write)     exp_bus = model_q.pop_front();
            else if (in_read)      exp_bus = resp_val;
            else                   exp_bus = 8'h00;
            exp_rdv = !rej && (cls == 2) && (c >= 3) && (c <= n + 2);

            check_val({tc, " sync"},  32'(data_sync), 32'(!rej && (c == 0)));
            check_val({tc, " bus"},   32'(data_bus),  32'(exp_bus));
            check_val({tc, " busy"},  32'(busy),      32'(!rej && (c <= gap)));
            check_val({tc, " done"},  32'(done),      32'(!rej && (c == gap)));
            check_val({tc, " err"},   32'(err),       32'(rej && (c == 0)));
            check_val({tc, " ready"}, 32'(cmd_ready), 32'(rej || (c > gap)));
            check_val({tc, " rdv"},   32'(rd_valid),  32'(exp_rdv));
            if (exp_rdv) check_val({tc, " rddata"}, 32'(rd_data), 32'(rd_q.pop_front()));

            if (c == rst_at) begin
                reset_n  = 1'b0;
                ld_valid = 1'b0;
                park();
                #1;
                check_reset_outputs({tc, " in_reset"});
                model_q.delete();
                @(posedge clk_in);
                @(posedge clk_in);
                #3;
                reset_n = 1'b1;
                #1;
                check_val({tc, " ready_before_edge"}, 32'(cmd_ready), 32'd0);
                @(posedge clk_in);
                #1;
                check_val({tc, " ready_after_edge"}, 32'(cmd_ready), 32'd1);
                return;
            end

            if (ld_now && !in_write && (model_q.size() < DEPTH)) model_q.push_back(ld_byte);
            @(posedge clk_in);
            #1;
        end
        ld_valid = 1'b0;
        park();
    endtask

    initial begin
        int         nl;
        logic [7:0] rc;
        logic [7:0] rl;

        reset_n   = 1'b1;
        ld_valid  = 1'b0;
        ld_data   = 8'h00;
        cmd_valid = 1'b0;
        cmd_code  = 8'h00;
        cmd_len   = 8'h00;
        park();
        #1;
        reset_n = 1'b0;
        #2;
        check_reset_outputs("por");
        #9;
        reset_n = 1'b1;
        #1;
        check_val("por ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk_in);
        #1;
        check_val("por ready_after_edge", 32'(cmd_ready), 32'd1);

        // 24-byte write of 0x00..0x17; the follow-up write proves the buffer is empty
        for (int i = 0; i < 24; i++) load_byte(8'(i));
        run_cmd(8'd1, 8'd24, 1'b0, -1, -1);
        run_cmd(8'd1, 8'd1, 1'b0, -1, -1);

        // read of seven bytes 0xA0..0xA6
        run_cmd(8'd2, 8'd7, 1'b0, 'hA0, -1);

        // over-long write rejected; the four queued bytes are still there
        for (int i = 0; i < 4; i++) load_byte(8'(8'hC0 + i));
        run_cmd(8'd3, 8'd6, 1'b0, -1, -1);
        run_cmd(8'd1, 8'd4, 1'b0, -1, -1);

        // strobe-only ignores its length; unknown codes rejected
        run_cmd(8'd5, 8'd33, 1'b0, -1, -1);
        run_cmd(8'd7, 8'd3, 1'b0, -1, -1);
        run_cmd(8'd10, 8'd0, 1'b0, -1, -1);

        // zero-length write and read, other read codes
        run_cmd(8'd1, 8'd0, 1'b0, -1, -1);
        run_cmd(8'd2, 8'd0, 1'b0, -1, -1);
        run_cmd(8'd4, 8'd1, 1'b0, -1, -1);
        run_cmd(8'd8, 8'd3, 1'b0, -1, -1);

        // pointer wrap, full buffer, and loading again after the drain
        for (int i = 0; i < 30; i++) load_byte(8'(8'h40 + i));
        run_cmd(8'd3, 8'd6, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) load_byte(8'(8'h60 + i));
        load_byte(8'hEE);
        run_cmd(8'd1, 8'd24, 1'b0, -1, -1);
        load_byte(8'h99);
        run_cmd(8'd1, 8'd10, 1'b0, -1, -1);
        run_cmd(8'd1, 8'd9, 1'b0, -1, -1);

        // reset in cycle 10 of a 24-byte write
        for (int i = 0; i < 24; i++) load_byte(8'(8'h80 + i));
        run_cmd(8'd1, 8'd24, 1'b0, -1, 10);
        run_cmd(8'd1, 8'd1, 1'b0, -1, -1);
        park();

        // randomized commands with loads arriving during transfers
        for (int k = 0; k < 60; k++) begin
            nl = $urandom_range(0, 12);
            for (int j = 0; j < nl; j++) load_byte(8'($urandom));
            if ($urandom_range(0, 7) == 0) rc = 8'($urandom);
            else rc = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rl = 8'(model_q.size());
            else rl = 8'($urandom_range(0, 12));
            run_cmd(rc, rl, 1'b1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
